sdram_to_usb: RTL



---
 rtl/sdram_to_usb.sv | 112 +++++++++++
 1 files changed

// File: rtl/sdram_to_usb.sv
// sdram_to_usb: reads WORD_COUNT 16-bit results over Wishbone and writes them to the FX2 IN FIFO.
// Define SDRAM_TO_USB_PREFETCH_EN to overlap the next read with the current FIFO write.
module sdram_to_usb #(
  parameter logic [31:0] BASE_ADDR  = 32'd0,
  parameter logic [15:0] WORD_COUNT = 16'd1024,
  parameter int          PKT_WORDS  = 256,
  parameter logic [1:0]  FIFO_ADDR  = 2'b10
) (
  input  logic        CLK,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  input  logic        FLAGD,
  output logic        SLWR,
  output logic        SLRD,
  output logic        SLOE,
  output logic        pktend,
  output logic [1:0]  FIFOADR,
  output logic [15:0] FDATA_out,
  output logic        FDATA_oe,
  input  logic [31:0] data_o,
  input  logic        stall_o,
  input  logic        sdram_ack,
  output logic        stb_i,
  output logic        cyc_i,
  output logic        we_i,
  output logic [3:0]  sel_i,
  output logic [31:0] addr_i,
  output logic [31:0] data_i
);
  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR, PKTEND, DONE} state_t;
  localparam logic [15:0] PKT_MASK = 16'(PKT_WORDS - 1);
  localparam logic SHORT_PKT = (WORD_COUNT & PKT_MASK) != 16'd0;
  state_t state, state_nx;
  logic [15:0] idx, hold;
  logic last, fire, unused_ok;
  assign last = idx + 16'd1 == WORD_COUNT;
`ifdef SDRAM_TO_USB_PREFETCH_EN
  localparam state_t NEXT_WORD = WR;
  logic [15:0] pf;
  logic pf_busy, pf_v, pf_req;
  // The next word is fetched while the current one waits for the FIFO; a write needs it in hand unless this is the last word.
  assign pf_req = state == WR && !last && !pf_busy && !pf_v;
  assign fire = state == WR && FLAGD && (last || pf_v);
  assign addr_i = BASE_ADDR + {16'd0, idx} + {31'd0, state == WR};
  assign stb_i = state == RD_REQ || pf_req;
  assign cyc_i = state == RD_REQ || state == RD_WAIT || pf_req || pf_busy;
  // Prefetch register: request outstanding, then valid until it moves into hold on a write.
  always_ff @(posedge CLK or negedge rst_n)
    if (!rst_n) begin
      pf_busy <= 1'b0;
      pf_v <= 1'b0;
      pf <= '0;
    end else begin
      if (pf_req && !stall_o) pf_busy <= 1'b1;
      if (pf_busy && sdram_ack) begin
        pf_busy <= 1'b0;
        pf_v <= 1'b1;
        pf <= data_o[15:0];
      end
      if (fire) pf_v <= 1'b0;
    end
`else
  localparam state_t NEXT_WORD = RD_REQ;
  assign fire = state == WR && FLAGD;
  assign addr_i = BASE_ADDR + {16'd0, idx};
  assign stb_i = state == RD_REQ;
  assign cyc_i = state == RD_REQ || state == RD_WAIT;
`endif
  assign unused_ok = &{1'b0, data_o[31:16]};
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign SLWR = !fire;
  assign pktend = state != PKTEND;
  assign FDATA_oe = state == WR;
  assign FDATA_out = FDATA_oe ? hold : 16'd0;
  assign SLRD = 1'b1;
  assign SLOE = 1'b1;
  assign FIFOADR = FIFO_ADDR;
  assign we_i = 1'b0;
  assign sel_i = 4'b0011;
  assign data_i = 32'd0;
  // Next-state: one read, one FIFO write per word; only a trailing short packet needs pktend.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = !start ? IDLE : WORD_COUNT == 16'd0 ? DONE : RD_REQ;
      RD_REQ:  state_nx = !stall_o ? RD_WAIT : RD_REQ;
      RD_WAIT: state_nx = sdram_ack ? WR : RD_WAIT;
      WR:      state_nx = !fire ? WR : !last ? NEXT_WORD : SHORT_PKT ? PKTEND : DONE;
      PKTEND:  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // State, word index and the hold register that feeds FDATA.
  always_ff @(posedge CLK or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      hold <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) idx <= '0;
      if (fire) idx <= idx + 16'd1;
      if (state == RD_WAIT && sdram_ack) hold <= data_o[15:0];
`ifdef SDRAM_TO_USB_PREFETCH_EN
      if (fire && pf_v) hold <= pf;
`endif
    end
endmodule
